// File: rtl/hsv_core_pkg.sv
// Shared core types: machine word and the flush controller state set.
package hsv_core_pkg;

   typedef logic [31:0] word;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      ACKED,
      REDIRECT
   } flush_state_t;

endpackage

// File: rtl/hsv_core_flush_min_counter.sv
// Saturating counter that times the minimum flush hold period.
// o_done is asserted on the cycle that completes MIN_FLUSH_CYCLES enabled
// cycles (the current enabled cycle is included), and stays asserted while
// the count sits at saturation.
module hsv_core_flush_min_counter
   import hsv_core_pkg::*;
#(
   parameter int unsigned MIN_FLUSH_CYCLES = 2
) (
   input  logic clk_core,
   input  logic rst_core_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_done
);

   localparam int unsigned W = $clog2(MIN_FLUSH_CYCLES + 1);
   localparam logic [W-1:0] C_MAX  = W'(MIN_FLUSH_CYCLES);
   localparam logic [W-1:0] C_LAST = W'(MIN_FLUSH_CYCLES - 1);

   logic [W-1:0] r_cnt;

   // Count enabled cycles, clear on request, hold at the saturation value.
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != C_MAX)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   // Done looks one increment ahead so the caller can act on the final cycle.
   always_comb begin
      o_done = (r_cnt == C_MAX) || (i_en && (r_cnt == C_LAST));
   end

endmodule

// File: rtl/hsv_core_flush_ctrl.sv
// Responder side of the core flush handshake: broadcasts flush to the
// pipeline units, waits for all of them to drain, acknowledges, then hands
// the latched redirect PC to fetch before releasing the handshake.
module hsv_core_flush_ctrl
   import hsv_core_pkg::*;
#(
   parameter int unsigned NUM_UNITS        = 4,
   parameter int unsigned MIN_FLUSH_CYCLES = 2
) (
   input  logic                 clk_core,
   input  logic                 rst_core_n,
   input  logic                 flush_req,
   input  logic [31:0]          flush_target,
   output logic                 flush_ack,
   output logic                 flush_o,
   input  logic [NUM_UNITS-1:0] unit_idle,
   output logic                 redirect_valid,
   input  logic                 redirect_ready,
   output logic [31:0]          redirect_pc
);

   flush_state_t r_state;
   flush_state_t w_state_nxt;

   logic        w_min_done;
   logic        w_all_idle;
   logic        w_pc_load;
   logic        w_flush_nxt;
   logic        w_ack_nxt;
   logic        w_rv_nxt;
   logic        r_flush_o;
   logic        r_flush_ack;
   logic        r_redirect_valid;
   logic [31:0] r_redirect_pc;

   hsv_core_flush_min_counter #(
      .MIN_FLUSH_CYCLES (MIN_FLUSH_CYCLES)
   ) u_min_counter (
      .clk_core   (clk_core),
      .rst_core_n (rst_core_n),
      .i_clr      (r_state == IDLE),
      .i_en       (r_state == DRAIN),
      .o_done     (w_min_done)
   );

   assign w_all_idle = &unit_idle;
   assign w_pc_load  = (r_state == ACKED) && !flush_req;

   // State register.
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic for the four-phase handshake.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:     if (flush_req)                          w_state_nxt = DRAIN;
         DRAIN:    if (w_min_done && w_all_idle)           w_state_nxt = ACKED;
         ACKED:    if (!flush_req)                         w_state_nxt = REDIRECT;
         REDIRECT: if (r_redirect_valid && redirect_ready) w_state_nxt = IDLE;
         default:                                          w_state_nxt = IDLE;
      endcase
   end

   // Output decode from the next state so every output leaves a flop.
   always_comb begin
      w_flush_nxt = (w_state_nxt != IDLE);
      w_ack_nxt   = (w_state_nxt == ACKED) || (w_state_nxt == REDIRECT);
      w_rv_nxt    = (w_state_nxt == REDIRECT);
   end

   // Output registers; redirect PC is captured word-aligned as req falls.
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         r_flush_o        <= 1'b0;
         r_flush_ack      <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_flush_o        <= w_flush_nxt;
         r_flush_ack      <= w_ack_nxt;
         r_redirect_valid <= w_rv_nxt;
         if (w_pc_load) begin
            r_redirect_pc <= flush_target & 32'hFFFF_FFFC;
         end
      end
   end

   assign flush_o        = r_flush_o;
   assign flush_ack      = r_flush_ack;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;

   // The initiator must hold flush_req until it has seen flush_ack.
   a_req_held_in_drain : assert property (
      @(posedge clk_core) disable iff (!rst_core_n)
      (r_state == DRAIN) |-> flush_req
   );

endmodule

// File: tb/tb_hsv_core_flush_ctrl.sv
// Bench for hsv_core_flush_ctrl: directed scenarios and randomized flush
// transactions checked every cycle against a timestamp-based reference.
module tb_hsv_core_flush_ctrl;

   localparam int MIN = 2;
   localparam int NU  = 4;

   logic          clk_core = 1'b0;
   logic          rst_core_n;
   logic          flush_req;
   logic [31:0]   flush_target;
   logic          flush_ack;
   logic          flush_o;
   logic [NU-1:0] unit_idle;
   logic          redirect_valid;
   logic          redirect_ready;
   logic [31:0]   redirect_pc;

   always #5 clk_core = ~clk_core;

   hsv_core_flush_ctrl #(
      .NUM_UNITS        (NU),
      .MIN_FLUSH_CYCLES (MIN)
   ) dut (
      .clk_core       (clk_core),
      .rst_core_n     (rst_core_n),
      .flush_req      (flush_req),
      .flush_target   (flush_target),
      .flush_ack      (flush_ack),
      .flush_o        (flush_o),
      .unit_idle      (unit_idle),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_pc    (redirect_pc)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference: each transaction is described by the cycles at which its
   // events take effect (start, ack rise, redirect rise, release).
   bit          m_busy;
   int          m_t0, m_ack, m_rv, m_end;
   logic [31:0] m_pc;

   int   ack_rise;
   logic prev_ack;

   function automatic void model_reset();
      m_busy = 0; m_t0 = -1; m_ack = -1; m_rv = -1; m_end = -1; m_pc = '0;
   endfunction

   function automatic void model_cycle(input int c, input logic req, input logic [3:0] idle,
                                       input logic rdy, input logic [31:0] tgt);
      if (m_busy && m_end >= 0 && c >= m_end) m_busy = 0;
      if (!m_busy) begin
         if (req) begin
            m_busy = 1; m_t0 = c; m_ack = -1; m_rv = -1; m_end = -1;
         end
      end else if (m_ack < 0) begin
         if (c >= m_t0 + MIN && idle == 4'hF) m_ack = c + 1;
      end else if (m_rv < 0) begin
         if (c >= m_ack && !req) begin
            m_rv = c + 1;
            m_pc = {tgt[31:2], 2'b00};
         end
      end else if (m_end < 0) begin
         if (c >= m_rv && rdy) m_end = c + 1;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_outputs(input int k);
      logic e_f, e_a, e_v;
      e_f = (m_t0 >= 0) && (k > m_t0) && (m_end < 0 || k < m_end);
      e_a = (m_ack >= 0) && (k >= m_ack) && (m_end < 0 || k < m_end);
      e_v = (m_rv >= 0) && (k >= m_rv) && (m_end < 0 || k < m_end);
      chk("flush_o", {31'd0, flush_o}, {31'd0, e_f});
      chk("flush_ack", {31'd0, flush_ack}, {31'd0, e_a});
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e_v});
      chk("redirect_pc", redirect_pc, m_pc);
   endtask

   task automatic step(input logic req, input logic [3:0] idle, input logic rdy,
                       input logic [31:0] tgt);
      flush_req = req; unit_idle = idle; redirect_ready = rdy; flush_target = tgt;
      @(posedge clk_core); #1;
      model_cycle(cyc, req, idle, rdy, tgt);
      cyc++;
      if (flush_ack && !prev_ack) ack_rise = cyc;
      prev_ack = flush_ack;
      check_outputs(cyc);
   endtask

   function automatic logic [3:0] rnd_busy(input logic [3:0] pat);
      return (pat == 4'hF) ? 4'($urandom_range(0, 14)) : pat;
   endfunction

   task automatic bound_chk(input string tag, input int guard);
      n_tests++;
      assert (guard < 400) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d got=timeout exp=event", tag, cyc);
      end
   endtask

   // One full flush: req rise, drain (busy units for 'stall' cycles), hold
   // req for 'hold' cycles after ack, drop req, delay ready by 'rdy_delay'.
   task automatic flush_txn(input logic [31:0] tgt, input int stall, input logic [3:0] pat,
                            input int hold, input int rdy_delay,
                            output int lat, output int total);
      int start, guard, k;
      start = cyc; ack_rise = -1;
      step(1'b1, (stall > 0) ? rnd_busy(pat) : 4'hF, 1'($urandom), tgt);
      guard = 0;
      while (!(m_ack >= 0 && cyc >= m_ack) && guard < 400) begin
         step(1'b1, (cyc - start < stall) ? rnd_busy(pat) : 4'hF, 1'($urandom), tgt);
         guard++;
      end
      bound_chk("ack_wait", guard);
      repeat (hold) step(1'b1, 4'($urandom), 1'($urandom), tgt);
      guard = 0;
      while (!(m_rv >= 0 && cyc >= m_rv) && guard < 400) begin
         step(1'b0, 4'($urandom), (rdy_delay == 0) ? 1'b1 : 1'($urandom), tgt);
         guard++;
      end
      bound_chk("rv_wait", guard);
      k = 0; guard = 0;
      while (!(m_end >= 0 && cyc >= m_end) && guard < 400) begin
         step(1'b0, 4'($urandom), (k >= rdy_delay), tgt);
         k++; guard++;
      end
      bound_chk("end_wait", guard);
      lat   = ack_rise - start;
      total = cyc - start;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, total, guard;
      logic [31:0] tgt;

      rst_core_n = 1'b0; flush_req = 1'b0; flush_target = '0;
      unit_idle = 4'hF; redirect_ready = 1'b0;
      model_reset(); prev_ack = 1'b0; ack_rise = -1;
      repeat (3) @(posedge clk_core);
      #1;
      check_outputs(cyc);
      rst_core_n = 1'b1;

      // Basic: ack at +3, req drop at +5, release at +7.
      flush_txn(32'h0000_1004, 0, 4'hF, 2, 0, lat, total);
      chk("basic_ack_latency", lat, MIN + 1);
      chk("basic_total", total, 7);
      chk("basic_pc", redirect_pc, 32'h0000_1004);

      // Slow drain: unit 3 busy until +10, ack at +11.
      flush_txn(32'h0000_2000, 10, 4'h7, 0, 0, lat, total);
      chk("slow_ack_latency", lat, 11);

      // Backpressure on the redirect, back-to-back with the previous flush.
      flush_txn(32'h0000_3008, 0, 4'hF, 1, 5, lat, total);
      chk("bp_ack_latency", lat, MIN + 1);

      // Unaligned target.
      flush_txn(32'h8000_0007, 0, 4'hF, 0, 0, lat, total);
      chk("unaligned_pc", redirect_pc, 32'h8000_0004);
      chk("unaligned_total", total, MIN + 1 + 2);

      // Wait-for-irq: req held long after ack.
      flush_txn(32'h0000_4444, 0, 4'hF, 100, 2, lat, total);
      chk("wfi_pc", redirect_pc, 32'h0000_4444);

      // Reset while a redirect is pending.
      tgt = 32'h0000_5550;
      step(1'b1, 4'hF, 1'b0, tgt);
      guard = 0;
      while (!(m_ack >= 0 && cyc >= m_ack) && guard < 400) begin
         step(1'b1, 4'hF, 1'b0, tgt); guard++;
      end
      guard = 0;
      while (!(m_rv >= 0 && cyc >= m_rv) && guard < 400) begin
         step(1'b0, 4'hF, 1'b0, tgt); guard++;
      end
      step(1'b0, 4'hF, 1'b0, tgt);
      #3 rst_core_n = 1'b0;
      #1;
      chk("rst_ack", {31'd0, flush_ack}, 32'd0);
      chk("rst_flush_o", {31'd0, flush_o}, 32'd0);
      chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
      chk("rst_pc", redirect_pc, 32'd0);
      model_reset();
      @(posedge clk_core); #1;
      cyc++;
      prev_ack = flush_ack;
      rst_core_n = 1'b1;
      repeat (5) step(1'b0, 4'($urandom), 1'($urandom), tgt);

      // Randomized transactions with random idle gaps between them.
      for (int t = 0; t < 40; t++) begin
         repeat ($urandom_range(0, 3)) step(1'b0, 4'($urandom), 1'($urandom), 32'($urandom));
         flush_txn(32'($urandom), $urandom_range(0, 6), 4'hF,
                   $urandom_range(0, 5), $urandom_range(0, 4), lat, total);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
